fifo_rd_prefetch: RTL and testbench
===================================

FIFO_RD_PREFETCH -- requirements
Module: fifo_rd_prefetch

Interface
REQ-001 Parameter MEM_WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-003 r_clk  input  1  read-domain clock; every register samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 w_ptr_gray_sync  input  ADDR_WIDTH+1  write pointer, Gray-coded, already synchronized into r_clk.
REQ-006 r_en  output  1  RAM read enable.
REQ-007 r_adrs  output  ADDR_WIDTH  RAM read address.
REQ-008 r_data  input  MEM_WIDTH  RAM read data; valid the cycle after r_en.
REQ-009 r_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to write domain.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  consumer accepts the word.
REQ-012 out_data  output  MEM_WIDTH  head word of output buffer.
REQ-013 fifo_empty  output  1  RAM holds no unread word (r_ptr_gray == w_ptr_gray_sync).

Function
REQ-014 Block SHALL keep binary read pointer rd_ptr; r_adrs = rd_ptr[ADDR_WIDTH-1:0]; r_ptr_gray = registered rd_ptr ^ (rd_ptr >> 1).
REQ-015 Block SHALL contain a 3-entry output buffer (count buf_cnt 0..3) and a 1-bit in-flight flag infl.
REQ-016 r_en SHALL be 1 iff !reset && !fifo_empty && (buf_cnt + infl) < 3, computed from registered state only; out_ready SHALL have no combinational path to r_en.
REQ-017 On r_en, rd_ptr SHALL increment by 1 modulo 2**(ADDR_WIDTH+1) and infl SHALL be set next cycle; otherwise infl cleared.
REQ-018 When infl is 1, r_data SHALL be written to buffer tail at that edge.
REQ-019 Transfer occurs when out_valid && out_ready; head pops at that edge; simultaneous push and pop SHALL leave buf_cnt unchanged and preserve order.
REQ-020 out_valid = (buf_cnt != 0); out_data = head entry, stable while out_valid && !out_ready.
REQ-021 Latency: w_ptr_gray_sync change in cycle N with empty buffer -> r_en in cycle N -> out_valid in cycle N+2.
REQ-022 Throughput SHALL be one word per cycle when out_ready held 1 and FIFO non-empty.
REQ-023 Pointer wrap: after 2**ADDR_WIDTH reads, MSB of rd_ptr toggles; fifo_empty SHALL remain correct across wrap.
REQ-024 Block SHALL never issue r_en while fifo_empty, and SHALL never overflow the output buffer.

Reset
REQ-025 While reset=1 at an edge: rd_ptr=0, r_ptr_gray=0, buf_cnt=0, infl=0, out_data=0; r_en=0 and out_valid=0 combinationally during reset.
REQ-026 Reset mid-operation SHALL discard buffered and in-flight words; r_data in the first cycle after reset deasserts SHALL be ignored.

Configuration
REQ-027 Macro FIFO_RD_LEVEL_EN: when defined, output rd_level (ADDR_WIDTH+2 bits) SHALL equal (bin(w_ptr_gray_sync) - rd_ptr) mod 2**(ADDR_WIDTH+1) + buf_cnt + infl, registered, reset 0; when undefined, port and logic SHALL be absent and all other behaviour identical.

Verification
REQ-028 Reset then w_ptr_gray_sync=0 -> r_en=0, out_valid=0, fifo_empty=1, r_ptr_gray=0 for 10 cycles.
REQ-029 Single word: RAM[0]=0xDEADBEEF, w_ptr_gray_sync 0->1 in cycle N, out_ready=1 -> r_en=1, r_adrs=0 in N; out_valid=1, out_data=0xDEADBEEF in N+2; r_ptr_gray=1 from N+1.
REQ-030 Backpressure: 8 words 0..7 written, out_ready=0 -> exactly 3 r_en pulses, buf_cnt=3; then out_ready=1 -> 0..7 delivered in order, one per cycle, no gaps.
REQ-031 Wrap: stream 20 words through depth-8 FIFO -> data in order, r_ptr_gray sequence matches Gray(1..20 mod 16), fifo_empty=1 at end.
REQ-032 Reset asserted with buf_cnt=2, infl=1 -> next cycle out_valid=0, rd_ptr=0; stale r_data not delivered.
REQ-033 With FIFO_RD_LEVEL_EN: 5 words written, out_ready=0 -> rd_level settles to 5.

Source files
------------

// File: rtl/fifo_rd_prefetch.sv
// Read side of an async FIFO: prefetches RAM words into a 3-entry output buffer.
// Optional FIFO_RD_LEVEL_EN adds a registered rd_level occupancy output.
module fifo_rd_prefetch #(
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray_sync,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_adrs,
  input  logic [MEM_WIDTH-1:0]  r_data,
  output logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MEM_WIDTH-1:0]  out_data,
  output logic                  fifo_empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] rd_level
`endif
);

  logic [ADDR_WIDTH:0]  rd_ptr;
  logic [ADDR_WIDTH:0]  rd_ptr_nxt;
  logic [1:0]           buf_cnt;
  logic                 infl;
  logic [MEM_WIDTH-1:0] buf_mem [3];
  logic [1:0]           head;
  logic [1:0]           tail;
  logic                 push;
  logic                 pop;

  function automatic logic [1:0] nxt_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Issue decision uses registered state only, so out_ready never reaches r_en.
  always_comb begin
    fifo_empty = (r_ptr_gray == w_ptr_gray_sync);
    r_en       = !reset && !fifo_empty && (({1'b0, buf_cnt} + {2'b00, infl}) < 3'd3);
    r_adrs     = rd_ptr[ADDR_WIDTH-1:0];
    rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, r_en};
    out_valid  = !reset && (buf_cnt != 2'd0);
    out_data   = buf_mem[head];
    push       = infl;
    pop        = out_valid && out_ready;
  end

  always_ff @(posedge r_clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      r_ptr_gray <= '0;
      buf_cnt    <= 2'd0;
      infl       <= 1'b0;
      head       <= 2'd0;
      tail       <= 2'd0;
      for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      r_ptr_gray <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
      infl       <= r_en;
      if (push) begin
        buf_mem[tail] <= r_data;
        tail          <= nxt_idx(tail);
      end
      if (pop) head <= nxt_idx(head);
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_WIDTH:0] w_ptr_bin;
  logic [ADDR_WIDTH:0] lvl_diff;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_ptr_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) w_ptr_bin[i] = ^(w_ptr_gray_sync >> i);
    lvl_diff = w_ptr_bin - rd_ptr;
  end

  always_ff @(posedge r_clk) begin
    if (reset) rd_level <= '0;
    else rd_level <= (ADDR_WIDTH+2)'(lvl_diff) + (ADDR_WIDTH+2)'(buf_cnt)
                     + (ADDR_WIDTH+2)'(infl);
  end
`endif

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Bench for fifo_rd_prefetch: RAM and write-side model, word queue scoreboard,
// latency model of issued reads. Define FIFO_RD_LEVEL_EN to also exercise rd_level.
module tb_fifo_rd_prefetch;

  logic        r_clk;
  logic        reset;
  logic [3:0]  w_gray;
  logic        r_en;
  logic [2:0]  r_adrs;
  logic [31:0] r_data;
  logic [3:0]  r_ptr_gray;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        fifo_empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [4:0]  rd_level;
`endif

  fifo_rd_prefetch #(.MEM_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .r_clk           (r_clk),
    .reset           (reset),
    .w_ptr_gray_sync (w_gray),
    .r_en            (r_en),
    .r_adrs          (r_adrs),
    .r_data          (r_data),
    .r_ptr_gray      (r_ptr_gray),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .fifo_empty      (fifo_empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level        (rd_level)
`endif
  );

  logic [31:0] mem [8];
  logic [31:0] q[$];
  logic [3:0]  w_bin;
  logic [3:0]  rcount;
  logic        ren_h1, ren_h2;
  int          landed, delivered, pushed;
  int          n_tests, n_fail;

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  // Synchronous RAM: data appears the cycle after r_en.
  always @(posedge r_clk) if (r_en) r_data <= mem[r_adrs];

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    mem[w_bin[2:0]] = d;
    w_bin  = w_bin + 4'd1;
    w_gray = gray(w_bin);
    q.push_back(d);
    pushed++;
  endtask

  task automatic model_clear();
    rcount = 4'd0; landed = 0; delivered = 0;
    ren_h1 = 1'b0; ren_h2 = 1'b0;
    q.delete();
  endtask

  // One cycle: check outputs against the model, then advance to the next negedge.
  task automatic step();
    logic [31:0] exp_d;
    #1;
    landed += int'(ren_h2);
    chk("r_ptr_gray", r_ptr_gray, gray(rcount));
    chk("fifo_empty", fifo_empty, (w_bin == rcount));
    chk("out_valid", out_valid, (landed != delivered));
    if (r_en) begin
      chk("r_adrs", r_adrs, rcount[2:0]);
      chk("r_en_nonempty", (w_bin != rcount), 1'b1);
    end
    if (out_valid && out_ready) begin
      exp_d = (q.size() != 0) ? q.pop_front() : 32'hxxxx_xxxx;
      chk("out_data", out_data, exp_d);
      delivered++;
    end
    ren_h2 = ren_h1;
    ren_h1 = r_en;
    if (r_en) rcount = rcount + 4'd1;
    @(posedge r_clk);
    @(negedge r_clk);
  endtask

  task automatic rand_phase(input int ncyc, input int nwords);
    logic [3:0] occ;
    int start;
    start = pushed;
    for (int c = 0; c < ncyc; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      occ = w_bin - rcount;
      if ((pushed - start) < nwords && occ < 4'd8 && $urandom_range(0, 2) != 0)
        push_word($urandom);
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) step();
    chk("drain_empty", fifo_empty, 1'b1);
    chk("drain_queue", q.size(), 0);
    chk("drain_count", pushed - start, nwords);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r0;
    n_tests = 0; n_fail = 0; pushed = 0;
    reset = 1'b1; out_ready = 1'b0; w_bin = 4'd0; w_gray = 4'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    model_clear();
    @(posedge r_clk); @(posedge r_clk); @(negedge r_clk);
    chk("rst_out_data", out_data, 32'h0);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_r_en", r_en, 1'b0);
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_empty", fifo_empty, 1'b1);
      chk("idle_gray", r_ptr_gray, 4'd0);
      step();
    end

    // Single word latency
    out_ready = 1'b1;
    push_word(32'hDEAD_BEEF);
    #1;
    chk("single_r_en", r_en, 1'b1);
    chk("single_r_adrs", r_adrs, 3'd0);
    step();
    chk("single_gray_n1", r_ptr_gray, 4'd1);
    chk("single_valid_n1", out_valid, 1'b0);
    step();
    chk("single_valid_n2", out_valid, 1'b1);
    chk("single_data_n2", out_data, 32'hDEAD_BEEF);
    step();
    step();
    chk("single_done", out_valid, 1'b0);

    // Backpressure: 8 words, consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(i);
    r0 = rcount;
    for (int i = 0; i < 8; i++) step();
    chk("bp_reads", rcount - r0, 4'd3);
    chk("bp_not_empty", fifo_empty, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_stream_valid", out_valid, 1'b1);
      chk("bp_stream_data", out_data, i);
      step();
    end
    for (int i = 0; i < 3; i++) step();
    chk("bp_end_empty", fifo_empty, 1'b1);
    chk("bp_end_valid", out_valid, 1'b0);

    // Random traffic with pointer wrap
    rand_phase(300, 40);

    // Reset with two words buffered and one in flight
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'hA5A5_0000 + i);
    step(); step(); step();
    chk("pre_rst_valid", out_valid, 1'b1);
    reset = 1'b1;
    w_bin = 4'd0; w_gray = 4'd0;
    #1;
    chk("rst_comb_r_en", r_en, 1'b0);
    chk("rst_comb_valid", out_valid, 1'b0);
    @(posedge r_clk); @(negedge r_clk);
    reset = 1'b0;
    model_clear();
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_gray", r_ptr_gray, 4'd0);
    chk("post_rst_adrs", r_adrs, 3'd0);
    chk("post_rst_empty", fifo_empty, 1'b1);
    for (int i = 0; i < 4; i++) step();

    rand_phase(200, 25);

`ifdef FIFO_RD_LEVEL_EN
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word($urandom);
    for (int i = 0; i < 6; i++) step();
    chk("rd_level", rd_level, 5'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("rd_level_drained", rd_level, 5'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
